// File: rtl/screen_pkg.sv
// screen_pkg: shared types and constants for the
// frame-synchronous screen selector / fader.
package screen_pkg;

  typedef enum logic [1:0] {
    SHOW,
    FADE_OUT,
    SWITCH,
    FADE_IN
  } fade_state_t;

  localparam int SCR_START    = 0;
  localparam int SCR_GAME     = 1;
  localparam int SCR_GAMEOVER = 2;

  localparam int RGB_W = 12;
  localparam int LVL_W = 5;

  typedef struct packed {
    logic             blank;
    logic [RGB_W-1:0] pix;
    logic [LVL_W-1:0] lvl;
  } s1_t;

endpackage

// File: rtl/rgb_scale.sv
// rgb_scale: combinational brightness scaling of a
// 12-bit {R4,G4,B4} pixel by level/STEPS.
module rgb_scale
  import screen_pkg::*;
#(
  parameter int STEPS = 8
) (
  input  logic [RGB_W-1:0] rgb,
  input  logic [LVL_W-1:0] level,
  output logic [RGB_W-1:0] scaled
);

  localparam int SH = $clog2(STEPS);

  for (genvar i = 0; i < 3; i++) begin : g_ch
    logic [7:0] prod;
    assign prod = 8'(rgb[4*i +: 4]) * 8'(level);
    assign scaled[4*i +: 4] = 4'(prod >> SH);
  end

endmodule

// File: rtl/screen_fade_sel.sv
// screen_fade_sel: picks an overlay or background per
// game state, switching only on frame boundaries.
module screen_fade_sel
  import screen_pkg::*;
#(
  parameter int N_SCREENS       = 3,
  parameter int SEL_W           = 2,
  parameter int FADE_EN         = 1,
  parameter int FADE_STEPS      = 8,
  parameter int FRAMES_PER_STEP = 2,
  parameter int RESET_SCREEN    = SCR_START
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SEL_W-1:0]           state,
  input  logic                       frame_start,
  input  logic [RGB_W-1:0]           rgb_bg,
  input  logic [N_SCREENS*RGB_W-1:0] rgb_in,
  input  logic [N_SCREENS-1:0]       valid_in,
  input  logic                       blank_in,
  output logic [RGB_W-1:0]           rgb_out,
  output logic                       blank_out,
  output logic                       busy,
  output logic [SEL_W-1:0]           active_sel
);

  localparam int FC_W =
    FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [LVL_W-1:0] LVL_MAX =
    LVL_W'(FADE_STEPS);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [SEL_W-1:0] SEL_RST =
    SEL_W'(RESET_SCREEN);

  fade_state_t      fs_q, fs_n;
  logic [LVL_W-1:0] lvl_q, lvl_n;
  logic [FC_W-1:0]  fc_q, fc_n;
  logic [SEL_W-1:0] sel_n;
  logic             step;
  logic             want;
  logic [RGB_W-1:0] pix;
  logic [RGB_W-1:0] scaled;
  s1_t              s1_q;

  // fade FSM, level, frame counter and selection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fs_q       <= SHOW;
      lvl_q      <= LVL_MAX;
      fc_q       <= '0;
      active_sel <= SEL_RST;
    end else begin
      fs_q       <= fs_n;
      lvl_q      <= lvl_n;
      fc_q       <= fc_n;
      active_sel <= sel_n;
    end
  end

  // next state, evaluated only on frame_start
  always_comb begin
    fs_n  = fs_q;
    lvl_n = lvl_q;
    fc_n  = fc_q;
    sel_n = active_sel;
    step  = (fc_q == FC_LAST);
    want  = (state != active_sel);
    if (frame_start) begin
      unique case (fs_q)
        SHOW: begin
          if (want) begin
            if (FADE_EN != 0) begin
              fs_n = FADE_OUT;
              fc_n = '0;
            end else begin
              sel_n = state;
            end
          end
        end
        FADE_OUT: begin
          if (!want) begin
            fc_n = '0;
            fs_n = (lvl_q == LVL_MAX) ? SHOW : FADE_IN;
          end else begin
            fc_n = step ? '0 : fc_q + FC_W'(1);
            if (step) begin
              lvl_n = lvl_q - LVL_ONE;
              if (lvl_q == LVL_ONE) fs_n = SWITCH;
            end
          end
        end
        SWITCH: begin
          sel_n = state;
          fs_n  = FADE_IN;
          fc_n  = '0;
        end
        FADE_IN: begin
          if (want) begin
            fc_n = '0;
            fs_n = (lvl_q == '0) ? SWITCH : FADE_OUT;
          end else begin
            fc_n = step ? '0 : fc_q + FC_W'(1);
            if (step) begin
              lvl_n = lvl_q + LVL_ONE;
              if (lvl_q == LVL_MAX - LVL_ONE) fs_n = SHOW;
            end
          end
        end
        default: fs_n = SHOW;
      endcase
    end
  end

  // busy while any transition is under way
  always_comb begin
    busy = (fs_q != SHOW);
  end

  // stage-1 source pick; out-of-range index is background
  always_comb begin
    pix = rgb_bg;
    for (int i = 0; i < N_SCREENS; i++) begin
      if (active_sel == SEL_W'(i) && valid_in[i])
        pix = rgb_in[i*RGB_W +: RGB_W];
    end
  end

  rgb_scale #(
    .STEPS (FADE_STEPS)
  ) u_scale (
    .rgb    (s1_q.pix),
    .level  (s1_q.lvl),
    .scaled (scaled)
  );

  // two-stage pixel pipeline with matched blank delay
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      rgb_out   <= '0;
      blank_out <= 1'b1;
    end else begin
      s1_q      <= '{blank: blank_in, pix: pix, lvl: lvl_q};
      rgb_out   <= s1_q.blank ? '0 : scaled;
      blank_out <= s1_q.blank;
    end
  end

endmodule

// File: tb/tb_screen_fade_sel.sv
// tb_screen_fade_sel: directed + random checks of the
// selector/fader against a frame-level reference model.
module tb_screen_fade_sel;

  localparam int NS    = 3;
  localparam int STEPS = 8;
  localparam int FPS   = 2;
  localparam int FLEN  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  state, state_b;
  logic        frame_start;
  logic [11:0] rgb_bg;
  logic [35:0] rgb_in;
  logic [2:0]  valid_in;
  logic        blank_in;
  logic [11:0] rgb_out, rgb_b;
  logic        blank_out, blank_b;
  logic        busy, busy_b;
  logic [1:0]  active_sel, sel_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  screen_fade_sel u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .frame_start (frame_start),
    .rgb_bg      (rgb_bg),
    .rgb_in      (rgb_in),
    .valid_in    (valid_in),
    .blank_in    (blank_in),
    .rgb_out     (rgb_out),
    .blank_out   (blank_out),
    .busy        (busy),
    .active_sel  (active_sel)
  );

  screen_fade_sel #(
    .FADE_EN (0)
  ) u_cut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state_b),
    .frame_start (frame_start),
    .rgb_bg      (rgb_bg),
    .rgb_in      (rgb_in),
    .valid_in    (valid_in),
    .blank_in    (blank_in),
    .rgb_out     (rgb_b),
    .blank_out   (blank_b),
    .busy        (busy_b),
    .active_sel  (sel_b)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference model: phase 0 show, 1 dimming,
  // 2 dark switch frame, 3 brightening
  int          m_ph, m_lvl, m_fc, m_sel, m_l1;
  logic [11:0] m_p1, m_rgb;
  bit          m_b1, m_bo;
  int          n_sel;
  logic [11:0] n_p1, n_rgb;
  bit          n_b1, n_bo;

  function automatic logic [11:0] pick(int sel);
    if (sel < NS && valid_in[sel])
      return rgb_in[sel*12 +: 12];
    return rgb_bg;
  endfunction

  function automatic logic [11:0] dim(logic [11:0] p,
                                      int lvl);
    logic [11:0] r;
    for (int c = 0; c < 3; c++)
      r[c*4 +: 4] = 4'((int'(p[c*4 +: 4]) * lvl) / STEPS);
    return r;
  endfunction

  task automatic model_fsm();
    bit want_out;
    int st;
    st = int'(state);
    if (m_ph == 0) begin
      if (st != m_sel) begin
        m_ph = 1;
        m_fc = 0;
      end
    end else if (m_ph == 2) begin
      m_sel = st;
      m_ph  = 3;
      m_fc  = 0;
    end else begin
      want_out = (st != m_sel);
      if (want_out != (m_ph == 1)) begin
        m_fc = 0;
        if (want_out) m_ph = (m_lvl == 0) ? 2 : 1;
        else m_ph = (m_lvl == STEPS) ? 0 : 3;
      end else begin
        m_fc++;
        if (m_fc == FPS) begin
          m_fc = 0;
          m_lvl = want_out ? m_lvl - 1 : m_lvl + 1;
          if (m_lvl == 0) m_ph = 2;
          if (m_lvl == STEPS) m_ph = 0;
        end
      end
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_ph = 0; m_lvl = STEPS; m_fc = 0; m_sel = 0;
      m_p1 = '0; m_l1 = 0; m_b1 = 0;
      m_rgb = '0; m_bo = 1;
      n_sel = 0; n_p1 = '0; n_b1 = 0;
      n_rgb = '0; n_bo = 1;
      return;
    end
    m_rgb = m_b1 ? 12'h000 : dim(m_p1, m_l1);
    m_bo  = m_b1;
    m_p1  = pick(m_sel);
    m_l1  = m_lvl;
    m_b1  = blank_in;
    n_rgb = n_b1 ? 12'h000 : n_p1;
    n_bo  = n_b1;
    n_p1  = pick(n_sel);
    n_b1  = blank_in;
    if (frame_start) begin
      model_fsm();
      n_sel = int'(state_b);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("rgb", rgb_out, m_rgb);
    chk("blank", blank_out, m_bo);
    chk("busy", busy, m_ph != 0);
    chk("sel", active_sel, m_sel);
    chk("rgb_b", rgb_b, n_rgb);
    chk("blank_b", blank_b, n_bo);
    chk("busy_b", busy_b, 0);
    chk("sel_b", sel_b, n_sel);
  endtask

  task automatic frame(int n);
    repeat (n) begin
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      repeat (FLEN - 1) cyc();
    end
  endtask

  initial begin
    rst_n = 0; state = 0; state_b = 0;
    frame_start = 0; rgb_bg = 0; rgb_in = 0;
    valid_in = 0; blank_in = 0;
    cyc();
    cyc();
    chk("rst_rgb", rgb_out, 0);
    chk("rst_blank", blank_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sel", active_sel, 0);
    rst_n = 1;

    valid_in = 3'b001;
    rgb_in[11:0] = 12'hF80;
    cyc();
    cyc();
    chk("opaque", rgb_out, 12'hF80);
    chk("opaque_busy", busy, 0);

    valid_in = 3'b000;
    rgb_bg = 12'h48C;
    cyc();
    cyc();
    chk("bg", rgb_out, 12'h48C);

    state_b = 2'd3;
    valid_in = 3'b111;
    rgb_in = {12'hFFF, 12'h0F0, 12'hFFF};
    frame(1);
    chk("cut_sel", sel_b, 3);
    chk("cut_bg", rgb_b, 12'h48C);

    state = 2'd2;
    for (int k = 0; k < 33; k++) begin
      frame(1);
      chk("fade_busy", busy, 1);
      if (k == 9) chk("fade_lvl4", rgb_out, 12'h777);
      if (k == 16) chk("sw_dark", rgb_out, 12'h000);
      if (k == 16) chk("sw_old", active_sel, 0);
      if (k == 17) chk("sw_sel", active_sel, 2);
    end
    frame(1);
    chk("fade_done", busy, 0);
    chk("fade_full", rgb_out, 12'hFFF);
    chk("fade_sel", active_sel, 2);

    state = 2'd0;
    frame(7);
    state = 2'd2;
    frame(1);
    chk("rev_lvl5", rgb_out, 12'h999);
    chk("rev_busy", busy, 1);
    frame(5);
    chk("rev_busy2", busy, 1);
    frame(1);
    chk("rev_done", busy, 0);
    chk("rev_sel", active_sel, 2);
    chk("rev_full", rgb_out, 12'hFFF);

    frame(1);
    state = 2'd1;
    cyc();
    state = 2'd0;
    cyc();
    state = 2'd2;
    frame(1);
    chk("toggle_busy", busy, 0);
    chk("toggle_sel", active_sel, 2);

    state = 2'd1;
    frame(24);
    chk("in_lvl3", rgb_out, 12'h050);
    chk("in_busy", busy, 1);
    rst_n = 0;
    cyc();
    chk("rst2_rgb", rgb_out, 0);
    chk("rst2_blank", blank_out, 1);
    chk("rst2_busy", busy, 0);
    chk("rst2_sel", active_sel, 0);
    rst_n = 1;
    frame(1);
    chk("rst2_full", rgb_out, 12'hFFF);

    for (int i = 0; i < 4000; i++) begin
      frame_start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0)
        state = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        state_b = 2'($urandom_range(0, 3));
      valid_in = 3'($urandom);
      rgb_in = 36'({$urandom(), $urandom()});
      rgb_bg = 12'($urandom);
      blank_in = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      cyc();
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/screen_fade_sel.md
Name: screen_fade_sel

Overview:
- Parametrised successor to the per-game-state screen selector.
- Picks one of N_SCREENS overlay sources, or the background, from the game state.
- Switches screens only at frame boundaries, with an optional fade-out/fade-in brightness transition over whole frames.
- Sits between the screen draw modules and the VGA output register; the 2-cycle pipeline latency is matched by a delayed blank flag.

Parameters:
- N_SCREENS, 3: number of selectable overlay sources (start, game, gameover, ...).
- SEL_W, 2: width of state; indices >= N_SCREENS mean background only.
- FADE_EN, 1: 1 = fade transitions; 0 = hard cut at frame_start.
- FADE_STEPS, 8: brightness levels per fade; power of 2, 2..16.
- FRAMES_PER_STEP, 2: frames held at each level, >= 1.
- RESET_SCREEN, 0: active screen index after reset.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active-low
- state  in  SEL_W  requested screen index (game FSM state)
- frame_start  in  1  one-cycle pulse at first pixel of each frame
- rgb_bg  in  12  background pixel {R4,G4,B4}
- rgb_in  in  N_SCREENS*12  packed overlay pixels; screen i at [12i+11:12i]
- valid_in  in  N_SCREENS  overlay i pixel is opaque
- blank_in  in  1  current pixel outside active area
- rgb_out  out  12  composited, scaled pixel; registered
- blank_out  out  1  blank_in delayed 2 cycles
- busy  out  1  transition in progress (FSM not SHOW)
- active_sel  out  SEL_W  screen currently displayed

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rgb_out=0, blank_out=1, busy=0.
  - active_sel=RESET_SCREEN, level=FADE_STEPS, frame counter=0, FSM=SHOW.
  - Pipeline registers are cleared.
  - Reset mid-fade aborts the fade immediately.
- Pipeline, 2 cycles:
  - Stage 1: pix = valid_in[active_sel] ? rgb_in[active_sel] : rgb_bg. If active_sel >= N_SCREENS, pix = rgb_bg.
  - Stage 2, each 4-bit channel: out = (c*level) >> log2(FADE_STEPS), computed in an 8-bit product. level=FADE_STEPS gives c exactly; level=0 gives 0.
  - blank_out=1 forces rgb_out=0.
  - level and active_sel are sampled in stage 1 and travel with the pixel, so no tearing occurs inside a frame.
- FSM state updates happen only on cycles with frame_start=1. Frame counter fc counts 0..FRAMES_PER_STEP-1 on frame_start pulses. A "step" means fc wraps.
  - SHOW:
    - If state != active_sel: with FADE_EN=1, go to FADE_OUT and set fc=0; with FADE_EN=0, load active_sel=state and stay in SHOW.
  - FADE_OUT:
    - Each step, level decrements by 1.
    - When level reaches 0, go to SWITCH.
    - If state == active_sel at a frame_start (request withdrawn), go to FADE_IN keeping the current level.
  - SWITCH (one frame at level 0):
    - At the next frame_start, load active_sel=state (latest value) and go to FADE_IN.
  - FADE_IN:
    - Each step, level increments by 1.
    - At level==FADE_STEPS, go to SHOW.
    - If state != active_sel at a frame_start, go to FADE_OUT keeping the current level.
- busy=1 whenever FSM != SHOW.
- Changes to state between frame_starts are ignored; only the value on frame_start cycles matters.
- Simultaneous frame_start and reset: reset wins.
- Out-of-range state is a legal target: it fades to and shows rgb_bg only.

Decomposition:
- Shared package (screen_pkg):
  - fade_state_t enum {SHOW, FADE_OUT, SWITCH, FADE_IN}.
  - Screen index constants SCR_START=0, SCR_GAME=1, SCR_GAMEOVER=2.
  - RGB_W=12.
- Natural sub-module: rgb_scale. A purely combinational per-channel multiply/shift of 12-bit RGB by level, reusable for other dimming effects.

Test Plan:
- Reset, then state=0, valid_in[0]=1, rgb_in[0]=12'hF80 -> rgb_out=12'hF80 two cycles after the pixel, busy=0.
- state=0, valid_in=0, rgb_bg=12'h48C -> rgb_out=12'h48C; state=3 (out of range) with FADE_EN=0 -> after next frame_start, rgb_out=rgb_bg regardless of valid_in.
- FADE_EN=1, STEPS=8, FPS=2: state 0->2 with rgb_in[0]=12'hFFF ->
  - levels 7..0 hold 2 frames each (8*2=16 frames; R at level 4 = 4'h7);
  - then 1 SWITCH frame, active_sel=2;
  - then 16 frames up to 12'hFFF of screen 2;
  - busy=1 throughout, low afterwards.
- Mid-FADE_OUT at level 5, state returns to 0 -> next frame_start goes to FADE_IN from 5, reaching 8 after 6 frames; active_sel stays 0.
- state toggles 0->1->0 between two frame_starts -> no transition, busy stays 0.
- rst_n=0 during FADE_IN at level 3 -> next cycle level=8, active_sel=RESET_SCREEN, busy=0, rgb_out=0, blank_out=1.
